// File: rtl/ahb_rr_arbiter_if.sv
// Arbitration signal bundle between AHB requesters and the round-robin arbiter.
// master: the requesting side of the bus; slave: the arbiter.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic                   HREADY;
  logic [1:0]             HTRANS;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTERD;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HREADY, HTRANS,
    input  HGRANT, HMASTER, HMASTERD, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HREADY, HTRANS,
    output HGRANT, HMASTER, HMASTERD, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with bounded tenure; grant registered, HMASTER one HREADY cycle later.
// HREADY=0 freezes every piece of state; locked owners are never pre-empted.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 8
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_rr_arbiter_if.slave bus
);
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [MW-1:0]   DEF_IDX  = MW'(DEFAULT_MASTER);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {PARK, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [MW-1:0]          owner, owner_nxt;
  logic [MW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [MW-1:0]          hmaster, hmaster_nxt;
  logic [MW-1:0]          hmasterd, hmasterd_nxt;
  logic                   hmastlock, hmastlock_nxt;
  logic [HW-1:0]          hold_cnt, hold_cnt_nxt;

  logic [MW-1:0]          scan_idx;
  logic [MW-1:0]          winner;
  logic                   any_req;
  logic                   others_req;
  logic                   locked;
  logic                   timeout;
  logic                   rearb;
  logic                   unused_ok;

  assign unused_ok = bus.HTRANS[0];

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan rr_ptr+1 .. rr_ptr+N so the current pointer is considered last.
  always_comb begin
    scan_idx = '0;
    winner   = rr_ptr;
    any_req  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = MW'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!any_req && bus.HBUSREQ[scan_idx]) begin
        winner  = scan_idx;
        any_req = 1'b1;
      end
    end
  end

  assign others_req = |(bus.HBUSREQ & ~grant);
  assign locked     = (state == OWNED) && bus.HLOCK[owner] && bus.HBUSREQ[owner];
  assign timeout    = (hold_cnt == HOLD_MAX);
  assign rearb      = !locked &&
                      ((state == PARK) || !bus.HBUSREQ[owner] || (timeout && others_req));

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    hmaster_nxt   = hmaster;
    hmasterd_nxt  = hmasterd;
    hmastlock_nxt = hmastlock;
    hold_cnt_nxt  = hold_cnt;
    if (bus.HREADY) begin
      hmaster_nxt   = owner;
      hmasterd_nxt  = hmaster;
      hmastlock_nxt = bus.HLOCK[owner];
      if (rearb) begin
        hold_cnt_nxt = '0;
        if (any_req) begin
          state_nxt  = OWNED;
          owner_nxt  = winner;
          rr_ptr_nxt = winner;
          grant_nxt  = onehot(winner);
        end else begin
          state_nxt  = PARK;
          owner_nxt  = DEF_IDX;
          grant_nxt  = onehot(DEF_IDX);
        end
      end else if (state == OWNED) begin
        // Timed out with nobody waiting: keep the bus but start a fresh tenure.
        if (timeout && !locked) begin
          hold_cnt_nxt = '0;
        end else if (bus.HTRANS[1] && !timeout) begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= PARK;
      grant     <= onehot(DEF_IDX);
      owner     <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
      hmaster   <= DEF_IDX;
      hmasterd  <= DEF_IDX;
      hmastlock <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      hmaster   <= hmaster_nxt;
      hmasterd  <= hmasterd_nxt;
      hmastlock <= hmastlock_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  assign bus.HGRANT    = grant;
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTERD  = hmasterd;
  assign bus.HMASTLOCK = hmastlock;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter (4 masters, park master 0, MAX_HOLD 8).
module tb_ahb_rr_arbiter;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] master;
    logic [1:0] masterd;
    logic       lock;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Expected address/data-phase pipeline state, derived from the grant sequence.
  logic [1:0] m_gidx;
  logic [1:0] m_master;
  logic [1:0] m_masterd;
  logic       m_lock;

  ahb_rr_arbiter_if #(.NUM_MASTERS(4), .MW(2)) bus ();

  ahb_rr_arbiter #(
    .NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0), .MAX_HOLD(8)
  ) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_grant"},   8'(bus.HGRANT),           8'(e.grant));
    chk({e.tag, "_onehot"},  8'($onehot(bus.HGRANT)),  8'd1);
    chk({e.tag, "_master"},  8'(bus.HMASTER),          8'(e.master));
    chk({e.tag, "_masterd"}, 8'(bus.HMASTERD),         8'(e.masterd));
    chk({e.tag, "_lock"},    8'(bus.HMASTLOCK),        8'(e.lock));
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] trans,
                      input logic rdy, input int g, input string tag);
    exp_t e;
    bus.HBUSREQ = req;
    bus.HLOCK   = lck;
    bus.HTRANS  = trans;
    bus.HREADY  = rdy;
    if (rdy) begin
      e.master  = m_gidx;
      e.masterd = m_master;
      e.lock    = lck[m_gidx];
    end else begin
      e.master  = m_master;
      e.masterd = m_masterd;
      e.lock    = m_lock;
    end
    e.grant   = 4'b0001 << g;
    e.tag     = tag;
    m_gidx    = 2'(g);
    m_master  = e.master;
    m_masterd = e.masterd;
    m_lock    = e.lock;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic reset_step(input logic [3:0] req, input logic [3:0] lck, input string tag);
    exp_t e;
    rst         = 1'b1;
    bus.HBUSREQ = req;
    bus.HLOCK   = lck;
    bus.HTRANS  = NONSEQ;
    bus.HREADY  = 1'b1;
    e.grant   = 4'b0001;
    e.master  = 2'd0;
    e.masterd = 2'd0;
    e.lock    = 1'b0;
    e.tag     = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    rst       = 1'b0;
    m_gidx    = 2'd0;
    m_master  = 2'd0;
    m_masterd = 2'd0;
    m_lock    = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HREADY  = 1'b1;
    m_gidx = 0; m_master = 0; m_masterd = 0; m_lock = 0;

    reset_step(4'b0000, 4'b0000, "reset");
    for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000, IDLE, 1'b1, 0, "park_idle");

    // Lone requester 3, then release back to the park master.
    step(4'b1000, 4'b0000, NONSEQ, 1'b1, 3, "m3_grant");
    step(4'b1000, 4'b0000, NONSEQ, 1'b1, 3, "m3_hmaster");
    step(4'b1000, 4'b0000, NONSEQ, 1'b1, 3, "m3_hmasterd");
    step(4'b0000, 4'b0000, IDLE,   1'b1, 0, "m3_release");
    step(4'b0000, 4'b0000, IDLE,   1'b1, 0, "park_m0a");
    step(4'b0000, 4'b0000, IDLE,   1'b1, 0, "park_m0b");

    // Masters 1 and 2 compete: each tenure lasts until hold_cnt reaches 8, then rotates.
    for (int k = 1; k <= 36; k++)
      step(4'b0110, 4'b0000, NONSEQ, 1'b1, (((k - 1) / 9) % 2 == 0) ? 1 : 2, "rr_1_2");

    // Master 2 locked: never pre-empted; unlock hands over at once since it has timed out.
    for (int i = 0; i < 20; i++) step(4'b0110, 4'b0100, NONSEQ, 1'b1, 2, "locked_m2");
    step(4'b0110, 4'b0000, NONSEQ, 1'b1, 1, "unlock_to_m1");

    // Handover to 3, then three wait states freeze everything.
    step(4'b1000, 4'b0000, NONSEQ, 1'b1, 3, "handover_m3");
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b0000, NONSEQ, 1'b0, 3, "wait_state");

    // Single requester past MAX_HOLD keeps the bus; the counter restarts, so a late
    // competitor only wins once the second tenure of 3 also reaches 8 beats.
    for (int i = 0; i < 13; i++) step(4'b1000, 4'b0000, NONSEQ, 1'b1, 3, "solo_m3");
    for (int i = 0; i < 4; i++)  step(4'b1001, 4'b0000, NONSEQ, 1'b1, 3, "m3_hold_vs_m0");
    step(4'b1001, 4'b0000, NONSEQ, 1'b1, 0, "timeout_to_m0");
    step(4'b1001, 4'b0000, NONSEQ, 1'b1, 0, "m0_owned");

    // Reset mid-transfer, then simultaneous requests at release start scanning after 0.
    reset_step(4'b1001, 4'b1001, "reset_mid");
    step(4'b1001, 4'b0000, NONSEQ, 1'b1, 3, "release_rr");
    step(4'b0000, 4'b0000, IDLE,   1'b1, 0, "final_park");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
Round-robin AHB bus arbiter sharing the system bus (Tube, memory slaves) among up to NUM_MASTERS request-only masters such as the Tube-writer masters. It samples per-master HBUSREQ/HLOCK and drives one-hot HGRANT, the address-phase owner HMASTER, the data-phase owner HMASTERD and HMASTLOCK, which steer the master-to-slave mux. A hold counter bounds bus tenure so that a master holding HBUSREQ permanently high cannot starve the others.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
MW, 2, width of master index, ceil(log2(NUM_MASTERS))
DEFAULT_MASTER, 0, index granted when nobody requests (park master)
MAX_HOLD, 8, maximum active beats (NONSEQ/SEQ with HREADY=1) before forced re-arbitration

Ports:
HCLK  in  1  bus clock; all state updates on rising edge
HRESET  in  1  synchronous reset, active-high
HBUSREQ  in  NUM_MASTERS  per-master bus request
HLOCK  in  NUM_MASTERS  per-master locked-transfer request
HREADY  in  1  bus HREADY from slave mux; all arbitration advances only when 1
HTRANS  in  2  HTRANS of the current address-phase owner (from master mux)
HGRANT  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  MW  address-phase owner index, registered
HMASTERD  out  MW  data-phase owner index (HMASTER delayed one HREADY cycle)
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Reset (HRESET=1 at edge, overrides everything, including mid-transfer): HGRANT=one-hot(DEFAULT_MASTER), HMASTER=HMASTERD=DEFAULT_MASTER, HMASTLOCK=0, hold_cnt=0, rr_ptr=DEFAULT_MASTER, state=PARK.
- States: PARK (grant to DEFAULT_MASTER, no requester) and OWNED (grant to a requesting master).
- Cycles with HREADY=0: HGRANT, HMASTER, HMASTERD, HMASTLOCK, hold_cnt, state and rr_ptr all hold.
- hold_cnt: +1 on each HREADY=1 cycle with HTRANS[1]=1 (NONSEQ/SEQ) while OWNED; saturates at MAX_HOLD; cleared when HGRANT changes.
- Re-arbitration point (HREADY=1) when any of: state=PARK; owner's HBUSREQ=0; hold_cnt=MAX_HOLD and any other HBUSREQ=1. Suppressed entirely while HLOCK[owner]=1 and HBUSREQ[owner]=1.
- Winner: first requester scanning indices rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_MASTERS, ending with rr_ptr itself (owner re-wins only if nobody else requests). Winner -> HGRANT one-hot next cycle, state=OWNED, rr_ptr=winner.
- No HBUSREQ set at re-arbitration point: HGRANT=one-hot(DEFAULT_MASTER), state=PARK, rr_ptr unchanged.
- Timeout with no other requester: owner keeps grant; hold_cnt cleared to 0.
- Handover latency: HGRANT changes at edge N; HMASTER takes the granted index at the first subsequent edge with HREADY=1; HMASTERD takes the old HMASTER at that same edge. Grant-to-HMASTER latency is therefore 1 cycle with HREADY=1, longer under wait states.
- HMASTLOCK updates with HMASTER: HLOCK[granted index] sampled at that edge.
- HGRANT is always exactly one-hot; HMASTER always equals the index of the previous HGRANT once HREADY has been 1.
- Simultaneous requests at reset release: winner is DEFAULT_MASTER+1 onward (rr_ptr=DEFAULT_MASTER).
- HBUSREQ bits at index >= NUM_MASTERS do not exist; no undefined index is ever produced.

Test Plan:
- Reset, no requests, HREADY=1: HGRANT=4'b0001, HMASTER=0, HMASTERD=0, HMASTLOCK=0 for 10 cycles; assert HRESET mid-transfer -> same values at next edge.
- Master 3 alone requests with HTRANS=NONSEQ: HGRANT=4'b1000 one cycle later, HMASTER=3 next cycle, HMASTERD=3 the cycle after; drop request -> HGRANT returns to 4'b0001.
- Masters 1 and 2 request continuously, MAX_HOLD=8, HTRANS=NONSEQ every cycle: grant alternates 1,2,1,2..., each tenure 8 active beats; masters 0 and 3 never granted.
- Master 2 with HLOCK=1 and master 1 requesting, 20 active beats: HGRANT stays 4'b0100, HMASTLOCK=1; drop HLOCK -> grant moves to master 1 at the next timeout point.
- Grant handover with HREADY=0 for 3 cycles: HGRANT, HMASTER and hold_cnt frozen; HMASTER updates only at the first edge with HREADY=1.
- Single requester exceeding MAX_HOLD beats: grant retained, hold_cnt wraps to 0, no one-hot glitch on HGRANT.
